// File: rtl/mod_reduce_25519.sv
`default_nettype none
// ============================================================================
//  Module   : mod_reduce_25519
//  Brief    : Folds a 512-bit product into its canonical residue mod 2^255-19
//             using 2^255 = 19 (mod q), then one conditional subtract of q.
//  Revision : 1.0  initial release
// ============================================================================
module mod_reduce_25519 #(
    parameter int IN_W     = 512,
    parameter int OUT_W    = 256,
    parameter int FOLD_MAX = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [IN_W-1:0]                   product,
    output logic                              busy,
    output logic                              done,
    output logic [OUT_W-1:0]                  result,
    output logic [$clog2(FOLD_MAX+1)-1:0]     folds
);

    localparam int CW    = $clog2(FOLD_MAX + 1);
    localparam int HI_W  = IN_W - 255;
    // 19 * hi needs 5 extra bits, plus one carry bit for the add
    localparam int SUM_W = HI_W + 6;
    localparam logic [OUT_W-1:0] C_Q = {{(OUT_W-255){1'b0}}, {247{1'b1}}, 8'hED};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_CORR = 2'd2
    } state_t;

    state_t           r_state;
    logic [IN_W-1:0]  r_acc;
    logic [CW-1:0]    r_fcnt;

    logic             w_hi_zero;
    logic [SUM_W-1:0] w_fold_sum;
    logic [OUT_W-1:0] w_acc_low;
    logic             w_ge_q;
    logic [OUT_W-1:0] w_acc_sub;

    assign w_hi_zero  = (r_acc[IN_W-1:255] == '0);
    assign w_fold_sum = SUM_W'(r_acc[254:0]) + (SUM_W'(r_acc[IN_W-1:255]) * SUM_W'(19));
    assign w_acc_low  = r_acc[OUT_W-1:0];
    assign w_ge_q     = (w_acc_low >= C_Q);
    assign w_acc_sub  = w_acc_low - C_Q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_fcnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            folds   <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // a start coinciding with the done pulse is dropped
                    if (start && !done) begin
                        r_acc   <= product;
                        r_fcnt  <= '0;
                        busy    <= 1'b1;
                        r_state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    if (w_hi_zero) begin
                        r_state <= S_CORR;
                    end else begin
                        r_acc  <= IN_W'(w_fold_sum);
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                S_CORR: begin
                    // acc < 2^255 < 2q here, so a single subtract is enough
                    result  <= w_ge_q ? w_acc_sub : w_acc_low;
                    folds   <= r_fcnt;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
